// File: rtl/seq_datapath_pkg.sv
// Shared encodings for the sequential datapath: bus sources, ALU operations
// and the multiply/divide sequencer states.
package seq_datapath_pkg;

    typedef enum logic [3:0] {
        SRC_NONE   = 4'd0,
        SRC_REG    = 4'd1,
        SRC_HI     = 4'd2,
        SRC_LO     = 4'd3,
        SRC_ZHI    = 4'd4,
        SRC_ZLO    = 4'd5,
        SRC_PC     = 4'd6,
        SRC_MDR    = 4'd7,
        SRC_INPORT = 4'd8,
        SRC_C      = 4'd9
    } bus_src_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SHR  = 4'd4,
        OP_SHRA = 4'd5,
        OP_SHL  = 4'd6,
        OP_ROR  = 4'd7,
        OP_ROL  = 4'd8,
        OP_NEG  = 4'd9,
        OP_NOT  = 4'd10,
        OP_MUL  = 4'd11,
        OP_DIV  = 4'd12
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative signed multiply (radix-2 Booth) and signed divide (restoring on
// magnitudes); one iteration per cycle, WIDTH iterations per operation.
module seq_muldiv import seq_datapath_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic               z_we,
    output logic [2*WIDTH-1:0] z_val,
    output logic               div_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_e state, state_nx;

    logic [WIDTH-1:0] opa, dvs, q, q_nx, quo, rem;
    logic [WIDTH:0]   acc, acc_nx, m_ext, booth_sum, rem_sh, rem_sub;
    logic             q1, q1_nx, div_mode, a_neg, b_neg, b_zero;
    logic [CW-1:0]    cnt;
    logic             last;

    assign last     = (cnt == LAST);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign z_we     = (state == ST_RUN) && last;
    assign div_zero = z_we && div_mode && b_zero;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_RUN;
            ST_RUN:  if (last)  state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // One iteration: for divide acc is the partial remainder and q shifts the
    // dividend out / quotient in; for multiply {acc,q,q1} is the Booth register.
    always_comb begin
        m_ext     = {opa[WIDTH-1], opa};
        booth_sum = acc;
        rem_sh    = '0;
        rem_sub   = '0;
        acc_nx    = acc;
        q_nx      = q;
        q1_nx     = q1;
        if (div_mode) begin
            rem_sh  = {acc[WIDTH-1:0], q[WIDTH-1]};
            rem_sub = rem_sh - {1'b0, dvs};
            if (!rem_sub[WIDTH]) begin
                acc_nx = rem_sub;
                q_nx   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_nx = rem_sh;
                q_nx   = {q[WIDTH-2:0], 1'b0};
            end
        end else begin
            case ({q[0], q1})
                2'b01:   booth_sum = acc + m_ext;
                2'b10:   booth_sum = acc - m_ext;
                default: booth_sum = acc;
            endcase
            {acc_nx, q_nx, q1_nx} = {booth_sum[WIDTH], booth_sum, q};
        end
    end

    always_comb begin
        quo   = (a_neg ^ b_neg) ? -q_nx : q_nx;
        rem   = a_neg ? -acc_nx[WIDTH-1:0] : acc_nx[WIDTH-1:0];
        z_val = {acc_nx[WIDTH-1:0], q_nx};
        if (div_mode) z_val = b_zero ? {opa, {WIDTH{1'b1}}} : {rem, quo};
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            opa      <= '0;
            dvs      <= '0;
            acc      <= '0;
            q        <= '0;
            q1       <= 1'b0;
            cnt      <= '0;
            div_mode <= 1'b0;
            a_neg    <= 1'b0;
            b_neg    <= 1'b0;
            b_zero   <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            opa      <= a;
            dvs      <= b[WIDTH-1] ? -b : b;
            acc      <= '0;
            q        <= is_div ? (a[WIDTH-1] ? -a : a) : b;
            q1       <= 1'b0;
            cnt      <= '0;
            div_mode <= is_div;
            a_neg    <= a[WIDTH-1];
            b_neg    <= b[WIDTH-1];
            b_zero   <= (b == '0);
        end else if (state == ST_RUN) begin
            acc <= acc_nx;
            q   <= q_nx;
            q1  <= q1_nx;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_datapath.sv
// Bus-based CPU datapath: register file, special registers, bus mux and a
// single-cycle ALU, with multiply/divide delegated to seq_muldiv.
module seq_datapath import seq_datapath_pkg::*; #(
    parameter int WIDTH   = 32,
    parameter int NREGS   = 16,
    parameter int R0_ZERO = 0,
    parameter int PC_STEP = 4,
    parameter int C_BITS  = 19
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         mem_data_in,
    input  logic [WIDTH-1:0]         inport_data,
    input  logic [3:0]               bus_src,
    input  logic [$clog2(NREGS)-1:0] reg_sel,
    input  logic                     Rin,
    input  logic                     PCin,
    input  logic                     IncPC,
    input  logic                     IRin,
    input  logic                     MARin,
    input  logic                     MDRin,
    input  logic                     MDRread,
    input  logic                     HIin,
    input  logic                     LOin,
    input  logic                     Yin,
    input  logic                     InPortin,
    input  logic                     OutPortin,
    input  logic [3:0]               alu_op,
    input  logic                     alu_start,
    output logic                     alu_busy,
    output logic                     alu_done,
    output logic                     div_by_zero,
    output logic [WIDTH-1:0]         bus_out,
    output logic [WIDTH-1:0]         ir_out,
    output logic [WIDTH-1:0]         mar_out,
    output logic [WIDTH-1:0]         outport_out
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW:0] WBITS = (SW + 1)'(WIDTH);
    localparam logic [WIDTH-1:0] PC_INC = WIDTH'(PC_STEP);
    localparam bit R0_HARD = (R0_ZERO != 0);

    logic [WIDTH-1:0]   rf [NREGS];
    logic [WIDTH-1:0]   pc, ir, mar, mdr, hi, lo, y, inport, outport;
    logic [2*WIDTH-1:0] z, md_z;
    logic [WIDTH-1:0]   bus, reg_rd, c_ext, alu_res;
    logic [SW-1:0]      shamt;
    logic [SW:0]        rot_l;
    logic               r0_sel, accept, single, md_start;
    logic               md_busy, md_done, md_z_we, md_dz, single_done, dbz;

    assign r0_sel = R0_HARD && (reg_sel == '0);
    assign reg_rd = r0_sel ? '0 : rf[reg_sel];
    assign c_ext  = {{(WIDTH-C_BITS){ir[C_BITS-1]}}, ir[C_BITS-1:0]};

    always_comb begin
        bus = '0;
        case (bus_src)
            SRC_REG:    bus = reg_rd;
            SRC_HI:     bus = hi;
            SRC_LO:     bus = lo;
            SRC_ZHI:    bus = z[2*WIDTH-1:WIDTH];
            SRC_ZLO:    bus = z[WIDTH-1:0];
            SRC_PC:     bus = pc;
            SRC_MDR:    bus = mdr;
            SRC_INPORT: bus = inport;
            SRC_C:      bus = c_ext;
            default:    bus = '0;
        endcase
    end

    // A is always Y, B is always the bus; unary ops (NEG/NOT) act on B.
    assign shamt = bus[SW-1:0];
    assign rot_l = WBITS - {1'b0, shamt};

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:  alu_res = y + bus;
            OP_SUB:  alu_res = y - bus;
            OP_AND:  alu_res = y & bus;
            OP_OR:   alu_res = y | bus;
            OP_SHR:  alu_res = y >> shamt;
            OP_SHRA: alu_res = $signed(y) >>> shamt;
            OP_SHL:  alu_res = y << shamt;
            OP_ROR:  alu_res = (y >> shamt) | (y << rot_l);
            OP_ROL:  alu_res = (y << shamt) | (y >> rot_l);
            OP_NEG:  alu_res = -bus;
            OP_NOT:  alu_res = ~bus;
            default: alu_res = '0;
        endcase
    end

    assign accept   = alu_start && !md_busy;
    assign md_start = accept && is_multicycle(alu_op);
    assign single   = accept && !is_multicycle(alu_op);

    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clock    (clock),
        .clear    (clear),
        .start    (md_start),
        .is_div   (alu_op == OP_DIV),
        .a        (y),
        .b        (bus),
        .busy     (md_busy),
        .done     (md_done),
        .z_we     (md_z_we),
        .z_val    (md_z),
        .div_zero (md_dz)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (Rin && !r0_sel) begin
            rf[reg_sel] <= bus;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            pc          <= '0;
            ir          <= '0;
            mar         <= '0;
            mdr         <= '0;
            hi          <= '0;
            lo          <= '0;
            y           <= '0;
            z           <= '0;
            inport      <= '0;
            outport     <= '0;
            single_done <= 1'b0;
            dbz         <= 1'b0;
        end else begin
            if (IncPC)     pc <= pc + PC_INC;
            else if (PCin) pc <= bus;
            if (IRin)      ir  <= bus;
            if (MARin)     mar <= bus;
            if (MDRin)     mdr <= MDRread ? mem_data_in : bus;
            if (HIin)      hi  <= bus;
            if (LOin)      lo  <= bus;
            if (Yin)       y   <= bus;
            if (InPortin)  inport  <= inport_data;
            if (OutPortin) outport <= bus;
            if (single)       z <= {{WIDTH{1'b0}}, alu_res};
            else if (md_z_we) z <= md_z;
            single_done <= single;
            if (accept)     dbz <= 1'b0;
            else if (md_dz) dbz <= 1'b1;
        end
    end

    assign alu_busy    = md_busy;
    assign alu_done    = single_done || md_done;
    assign div_by_zero = dbz;
    assign bus_out     = bus;
    assign ir_out      = ir;
    assign mar_out     = mar;
    assign outport_out = outport;

endmodule

// File: tb/tb_seq_datapath.sv
// Scenario bench for seq_datapath: ALU results flow through an expected-value
// queue filled at launch and drained when the DUT signals completion.
module tb_seq_datapath;
    import seq_datapath_pkg::*;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         clear = 1'b1;
    logic [W-1:0] mem_data_in, inport_data;
    logic [3:0]   bus_src, alu_op, reg_sel;
    logic         Rin, PCin, IncPC, IRin, MARin, MDRin, MDRread;
    logic         HIin, LOin, Yin, InPortin, OutPortin, alu_start;
    logic         alu_busy, alu_done, div_by_zero;
    logic [W-1:0] bus_out, ir_out, mar_out, outport_out;
    logic         zb_busy, zb_done, zb_dbz;
    logic [W-1:0] zb_bus, zb_ir, zb_mar, zb_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    always #5 clock = ~clock;

    seq_datapath #(.R0_ZERO(0)) dut (
        .clock(clock), .clear(clear), .mem_data_in(mem_data_in), .inport_data(inport_data),
        .bus_src(bus_src), .reg_sel(reg_sel), .Rin(Rin), .PCin(PCin), .IncPC(IncPC),
        .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .MDRread(MDRread), .HIin(HIin),
        .LOin(LOin), .Yin(Yin), .InPortin(InPortin), .OutPortin(OutPortin),
        .alu_op(alu_op), .alu_start(alu_start), .alu_busy(alu_busy), .alu_done(alu_done),
        .div_by_zero(div_by_zero), .bus_out(bus_out), .ir_out(ir_out), .mar_out(mar_out),
        .outport_out(outport_out)
    );

    seq_datapath #(.R0_ZERO(1)) dut_z (
        .clock(clock), .clear(clear), .mem_data_in(mem_data_in), .inport_data(inport_data),
        .bus_src(bus_src), .reg_sel(reg_sel), .Rin(Rin), .PCin(PCin), .IncPC(IncPC),
        .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .MDRread(MDRread), .HIin(HIin),
        .LOin(LOin), .Yin(Yin), .InPortin(InPortin), .OutPortin(OutPortin),
        .alu_op(alu_op), .alu_start(alu_start), .alu_busy(zb_busy), .alu_done(zb_done),
        .div_by_zero(zb_dbz), .bus_out(zb_bus), .ir_out(zb_ir), .mar_out(zb_mar),
        .outport_out(zb_out)
    );

    function automatic logic [63:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        logic [63:0] aa;
        longint sa, sb;
        int s;
        aa = {a, a};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = int'(b[4:0]);
        case (op)
            OP_ADD:  return {32'h0, a + b};
            OP_SUB:  return {32'h0, a - b};
            OP_AND:  return {32'h0, a & b};
            OP_OR:   return {32'h0, a | b};
            OP_SHR:  return {32'h0, a >> s};
            OP_SHRA: return {32'h0, W'($signed(a) >>> s)};
            OP_SHL:  return {32'h0, a << s};
            OP_ROR:  return {32'h0, W'(aa >> s)};
            OP_ROL:  return {32'h0, 32'(aa >> (32 - s))};
            OP_NEG:  return {32'h0, -b};
            OP_NOT:  return {32'h0, ~b};
            OP_MUL:  return 64'(sa * sb);
            OP_DIV:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {W'(sa % sb), W'(sa / sb)};
            default: return 64'h0;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_ctl();
        {Rin, PCin, IncPC, IRin, MARin, MDRin, MDRread} = '0;
        {HIin, LOin, Yin, InPortin, OutPortin, alu_start} = '0;
        bus_src = SRC_NONE;
        alu_op = OP_ADD;
        reg_sel = '0;
        mem_data_in = '0;
        inport_data = '0;
    endtask

    task automatic set_inport(input logic [W-1:0] v);
        inport_data = v;
        InPortin = 1'b1;
        cyc();
        InPortin = 1'b0;
    endtask

    task automatic ld_reg(input int r, input logic [W-1:0] v);
        set_inport(v);
        bus_src = SRC_INPORT;
        reg_sel = 4'(r);
        Rin = 1'b1;
        cyc();
        Rin = 1'b0;
        bus_src = SRC_NONE;
    endtask

    task automatic ld_y(input int r);
        bus_src = SRC_REG;
        reg_sel = 4'(r);
        Yin = 1'b1;
        cyc();
        Yin = 1'b0;
        bus_src = SRC_NONE;
    endtask

    task automatic peek(input logic [3:0] src, input int r, output logic [W-1:0] v);
        bus_src = src;
        reg_sel = 4'(r);
        #1;
        v = bus_out;
    endtask

    // Launch an op with B = R[r]; returns Z as seen once alu_done rises.
    task automatic run_op(input logic [3:0] op, input int r, input logic [63:0] e,
                          output logic [63:0] got, output int lat);
        logic [W-1:0] hi, lo;
        bus_src = SRC_REG;
        reg_sel = 4'(r);
        alu_op = op;
        alu_start = 1'b1;
        exp_q.push_back(e);
        cyc();
        alu_start = 1'b0;
        lat = 1;
        while (!alu_done && lat < 200) begin
            cyc();
            lat++;
        end
        peek(SRC_ZHI, 0, hi);
        peek(SRC_ZLO, 0, lo);
        got = {hi, lo};
        cyc();
        bus_src = SRC_NONE;
    endtask

    task automatic test_reset();
        logic [W-1:0] v;
        idle_ctl();
        #2 clear = 1'b0;
        cyc();
        n_checks++;
        if ({alu_busy, alu_done, div_by_zero} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000", {alu_busy, alu_done, div_by_zero});
        end
        n_checks++;
        if ({ir_out, mar_out, outport_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outs: got %h %h %h want 0", ir_out, mar_out, outport_out);
        end
        n_checks++;
        if ({zb_busy, zb_done, zb_dbz, zb_bus, zb_ir, zb_mar, zb_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_r0dut: outputs not zero");
        end
        peek(SRC_PC, 0, v);
        n_checks++;
        if (v !== '0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", v); end
        peek(SRC_ZLO, 0, v);
        n_checks++;
        if (v !== '0) begin n_fail++; $display("FAIL reset_zlo: got %h want 0", v); end
        cyc();
        clear = 1'b1;
        cyc();
    endtask

    task automatic test_add();
        logic [63:0] got, e;
        int lat;
        ld_reg(3, 32'h0000_0005);
        ld_y(3);
        run_op(OP_ADD, 3, 64'h0000_0000_0000_000A, got, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL add_result: got %h want %h", got, e); end
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d want 1", lat); end
        n_checks++;
        if ({alu_done, alu_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL add_pulse: done/busy got %b want 00", {alu_done, alu_busy});
        end
    endtask

    task automatic test_single_ops();
        alu_op_e ops[11] = '{OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
                             OP_ROR, OP_ROL, OP_NEG, OP_NOT, OP_ROR};
        logic [W-1:0] a = 32'h8000_00F1;
        logic [63:0] got, e;
        int lat, r;
        ld_reg(1, a);
        ld_reg(4, 32'd4);
        ld_reg(5, 32'd0);
        ld_y(1);
        foreach (ops[i]) begin
            r = (i == 10) ? 5 : 4;
            run_op(ops[i], r, model(ops[i], a, (r == 5) ? 32'd0 : 32'd4), got, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e || lat !== 1) begin
                n_fail++;
                $display("FAIL single_op_%0d: got %h lat %0d want %h lat 1", ops[i], got, lat, e);
            end
        end
    endtask

    task automatic test_mul();
        logic [W-1:0] hi, lo;
        logic [63:0] e, got;
        int busy_cnt = 0, done_cnt = 0, done_at = -1, lat;
        ld_reg(1, -32'sd3);
        ld_reg(2, 32'd7);
        ld_y(1);
        bus_src = SRC_REG;
        reg_sel = 4'd2;
        alu_op = OP_MUL;
        alu_start = 1'b1;
        exp_q.push_back(model(OP_MUL, -32'sd3, 32'd7));
        cyc();
        alu_start = 1'b0;
        while (alu_busy && busy_cnt < 100) begin
            busy_cnt++;
            if (alu_done) begin done_cnt++; done_at = busy_cnt; end
            // a start while busy must be dropped; Y reload must not disturb the op
            alu_start = (busy_cnt == 5);
            alu_op = (busy_cnt == 5) ? OP_ADD : OP_MUL;
            Yin = (busy_cnt == 10);
            cyc();
        end
        alu_start = 1'b0;
        Yin = 1'b0;
        n_checks++;
        if (busy_cnt !== 33) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d want 33", busy_cnt); end
        n_checks++;
        if (done_cnt !== 1 || done_at !== 33) begin
            n_fail++;
            $display("FAIL mul_done_pulse: got %0d pulses at %0d want 1 at 33", done_cnt, done_at);
        end
        peek(SRC_ZHI, 0, hi);
        peek(SRC_ZLO, 0, lo);
        e = exp_q.pop_front();
        n_checks++;
        if ({hi, lo} !== e) begin n_fail++; $display("FAIL mul_neg3x7: got %h want %h", {hi, lo}, e); end
        cyc();
        run_op(OP_ADD, 2, 64'd14, got, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL y_reload_in_run: got %h want %h", got, e); end
    endtask

    task automatic test_mul_table();
        logic [W-1:0] as[6] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
        logic [W-1:0] bs[6] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
        logic [63:0] got, e;
        int lat;
        for (int i = 3; i < 6; i++) begin
            as[i] = $urandom;
            bs[i] = $urandom;
        end
        foreach (as[i]) begin
            ld_reg(1, as[i]);
            ld_reg(2, bs[i]);
            ld_y(1);
            run_op(OP_MUL, 2, model(OP_MUL, as[i], bs[i]), got, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e || lat !== 33) begin
                n_fail++;
                $display("FAIL mul_%h_%h: got %h lat %0d want %h lat 33", as[i], bs[i], got, lat, e);
            end
        end
    endtask

    task automatic test_div();
        logic [W-1:0] as[7] = '{-32'sd7, 32'd7, -32'sd100, 32'h8000_0000, 32'h0, 32'h0, 32'h0};
        logic [W-1:0] bs[7] = '{32'd2, -32'sd2, 32'd7, 32'd3, 32'h0, 32'h0, 32'h0};
        logic [63:0] got, e;
        int lat;
        for (int i = 4; i < 7; i++) begin
            as[i] = $urandom;
            bs[i] = {16'h0, 16'($urandom)} | 32'd1;
            if (i == 5) bs[i] = -bs[i];
        end
        foreach (as[i]) begin
            ld_reg(1, as[i]);
            ld_reg(2, bs[i]);
            ld_y(1);
            run_op(OP_DIV, 2, model(OP_DIV, as[i], bs[i]), got, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e || lat !== 33 || div_by_zero !== 1'b0) begin
                n_fail++;
                $display("FAIL div_%h_%h: got %h lat %0d dbz %b want %h lat 33 dbz 0",
                         as[i], bs[i], got, lat, div_by_zero, e);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [63:0] got, e;
        int lat;
        ld_reg(1, -32'sd7);
        ld_reg(2, 32'd0);
        ld_y(1);
        run_op(OP_DIV, 2, {-32'sd7, 32'hFFFF_FFFF}, got, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL div0_result: got %h want %h", got, e); end
        cyc();
        cyc();
        n_checks++;
        if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL div0_sticky: got %b want 1", div_by_zero); end
        ld_reg(3, 32'd1);
        run_op(OP_ADD, 3, 64'hFFFF_FFFA, got, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (div_by_zero !== 1'b0 || got !== e) begin
            n_fail++;
            $display("FAIL div0_clear: dbz %b z %h want dbz 0 z %h", div_by_zero, got, e);
        end
    endtask

    task automatic test_pc();
        logic [W-1:0] v;
        set_inport(32'hFFFF_FFFC);
        bus_src = SRC_INPORT;
        PCin = 1'b1;
        cyc();
        set_inport(32'h0000_0100);
        bus_src = SRC_INPORT;
        PCin = 1'b1;
        IncPC = 1'b1;
        cyc();
        {PCin, IncPC} = 2'b00;
        peek(SRC_PC, 0, v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL pc_wrap_incwins: got %h want 0", v); end
        IncPC = 1'b1;
        cyc();
        IncPC = 1'b0;
        peek(SRC_PC, 0, v);
        n_checks++;
        if (v !== 32'h4) begin n_fail++; $display("FAIL pc_inc: got %h want 4", v); end
        bus_src = SRC_INPORT;
        PCin = 1'b1;
        cyc();
        PCin = 1'b0;
        peek(SRC_PC, 0, v);
        n_checks++;
        if (v !== 32'h100) begin n_fail++; $display("FAIL pc_load: got %h want 100", v); end
    endtask

    task automatic test_regs();
        logic [W-1:0] v, v2;
        mem_data_in = 32'hDEAD_BEEF;
        {MDRin, MDRread} = 2'b11;
        cyc();
        {MDRin, MDRread} = 2'b00;
        peek(SRC_MDR, 0, v);
        n_checks++;
        if (v !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mdr_mem: got %h want deadbeef", v); end
        set_inport(32'h0000_0055);
        bus_src = SRC_INPORT;
        MDRin = 1'b1;
        HIin = 1'b1;
        OutPortin = 1'b1;
        cyc();
        {MDRin, HIin, OutPortin} = '0;
        peek(SRC_MDR, 0, v);
        n_checks++;
        if (v !== 32'h55 || outport_out !== 32'h55) begin
            n_fail++;
            $display("FAIL mdr_bus_outport: got %h %h want 55 55", v, outport_out);
        end
        set_inport(32'h0004_0123);
        bus_src = SRC_INPORT;
        IRin = 1'b1;
        LOin = 1'b1;
        MARin = 1'b1;
        cyc();
        {IRin, LOin, MARin} = '0;
        peek(SRC_C, 0, v);
        peek(SRC_HI, 0, v2);
        n_checks++;
        if (v !== 32'hFFFC_0123 || ir_out !== 32'h0004_0123 || mar_out !== 32'h0004_0123 || v2 !== 32'h55) begin
            n_fail++;
            $display("FAIL ir_c_mar_hi: c %h ir %h mar %h hi %h want fffc0123 40123 40123 55",
                     v, ir_out, mar_out, v2);
        end
        peek(SRC_LO, 0, v);
        n_checks++;
        if (v !== 32'h0004_0123) begin n_fail++; $display("FAIL lo_load: got %h want 40123", v); end
        set_inport(32'hFFF3_0123);
        bus_src = SRC_INPORT;
        IRin = 1'b1;
        cyc();
        IRin = 1'b0;
        peek(SRC_C, 0, v);
        n_checks++;
        if (v !== 32'h0003_0123) begin n_fail++; $display("FAIL c_positive: got %h want 30123", v); end
        peek(4'd15, 0, v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL bus_unused_code: got %h want 0", v); end
    endtask

    task automatic test_r0();
        logic [W-1:0] v;
        set_inport(32'h0000_1234);
        bus_src = SRC_INPORT;
        reg_sel = 4'd0;
        Rin = 1'b1;
        cyc();
        Rin = 1'b0;
        peek(SRC_REG, 0, v);
        n_checks++;
        if (zb_bus !== 32'h0) begin n_fail++; $display("FAIL r0_zero: got %h want 0", zb_bus); end
        n_checks++;
        if (v !== 32'h1234) begin n_fail++; $display("FAIL r0_ordinary: got %h want 1234", v); end
    endtask

    task automatic test_abort();
        logic [W-1:0] hi, lo;
        logic [63:0] got, e;
        int done_cnt = 0, lat;
        ld_reg(1, -32'sd3);
        ld_reg(2, 32'd7);
        ld_y(1);
        bus_src = SRC_REG;
        reg_sel = 4'd2;
        alu_op = OP_MUL;
        alu_start = 1'b1;
        exp_q.push_back(64'h0);
        cyc();
        alu_start = 1'b0;
        for (int i = 1; i < 10; i++) cyc();
        n_checks++;
        if (alu_busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b want 1", alu_busy); end
        #2 clear = 1'b0;
        #1;
        n_checks++;
        if (alu_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_after: got %b want 0", alu_busy); end
        #1 clear = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (alu_done) done_cnt++;
        end
        n_checks++;
        if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt); end
        peek(SRC_ZHI, 0, hi);
        peek(SRC_ZLO, 0, lo);
        e = exp_q.pop_front();
        n_checks++;
        if ({hi, lo} !== e) begin n_fail++; $display("FAIL abort_z: got %h want %h", {hi, lo}, e); end
        cyc();
        ld_reg(1, -32'sd3);
        ld_reg(2, 32'd7);
        ld_y(1);
        run_op(OP_MUL, 2, 64'hFFFF_FFFF_FFFF_FFEB, got, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e || lat !== 33) begin
            n_fail++;
            $display("FAIL abort_rerun: got %h lat %0d want %h lat 33", got, lat, e);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want finish before 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_single_ops();
        test_mul();
        test_mul_table();
        test_div();
        test_div_zero();
        test_pc();
        test_regs();
        test_r0();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
